// File: rtl/uart_arb_pkg.sv
// Types and defaults shared by the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_arb_rr_pick.sv
// Rotating-priority encoder: first set request at or above i_ptr, wrapping to 0.
// Purely combinational; o_any flags that at least one request is set.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_any
);
    logic w_found;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && i_req[j] && (((int'(i_ptr) + k) % N) == j)) begin
                    o_pick[j] = 1'b1;
                    w_found   = 1'b1;
                end
            end
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX byte path among N_REQ sources; registered output byte.
// Optional message lock with stall timeout is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_MAX = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    tx_valid_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_ready_i,
    output logic                    busy_o,
    output logic                    timeout_o
);
    localparam int IW = idx_w(N_REQ);

    arb_state_e        r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_grant;
    logic [IW-1:0]     r_gidx;
    logic [IW-1:0]     r_ptr;
    logic              r_tx_vld;
    logic [DATA_W-1:0] r_tx_dat;

    logic [N_REQ-1:0]  w_pick;
    logic              w_any;
    logic [IW-1:0]     w_pick_idx;
    logic [IW-1:0]     w_ptr_nxt;
    logic              w_tx_free;
    logic              w_accept;
    logic              w_release;
    logic [DATA_W-1:0] w_sel_dat;
    logic              w_sel_last;

    uart_arb_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req  (req_valid_i),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    always_comb begin
        w_pick_idx = '0;
        w_sel_dat  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_pick[j])  w_pick_idx = IW'(j);
            if (r_grant[j]) w_sel_dat  = w_sel_dat | req_data_i[j*DATA_W +: DATA_W];
        end
    end

    assign w_sel_last = |(req_last_i & r_grant);
    assign w_tx_free  = !r_tx_vld || tx_ready_i;
    assign w_accept   = (r_state == GRANT) && w_tx_free && |(req_valid_i & r_grant);
    assign w_ptr_nxt  = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + IW'(1);

`ifdef UART_ARB_LOCK_EN
    logic [15:0] r_hold;
    logic        r_timeout;
    logic        w_hold_hit;

    assign w_hold_hit = (r_state == GRANT) && !w_accept && (r_hold == 16'(HOLD_MAX));
    assign w_release  = (w_accept && w_sel_last) || w_hold_hit;
    assign timeout_o  = r_timeout;

    // Counts consecutive granted cycles with no byte accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_hold_hit;
            if (r_state != GRANT || w_accept || w_hold_hit) r_hold <= '0;
            else                                             r_hold <= r_hold + 16'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{w_sel_last, 32'(HOLD_MAX)};
    assign w_release = w_accept;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)     w_state_nxt = GRANT;
            GRANT:   if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (r_state == GRANT && w_tx_free) req_ready_o = r_grant;
    end

    // A new accept wins over the handshake so back-to-back bytes leave no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant  <= '0;
            r_gidx   <= '0;
            r_ptr    <= '0;
            r_tx_vld <= 1'b0;
            r_tx_dat <= '0;
        end else begin
            if (w_accept) begin
                r_tx_vld <= 1'b1;
                r_tx_dat <= w_sel_dat;
            end else if (tx_ready_i) begin
                r_tx_vld <= 1'b0;
            end
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
                r_gidx  <= w_pick_idx;
            end else if (r_state == GRANT && w_release) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign grant_o    = r_grant;
    assign tx_valid_o = r_tx_vld;
    assign tx_data_o  = r_tx_dat;
    assign busy_o     = (r_state != IDLE) || r_tx_vld;
endmodule
